calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 140 ++++++++++++++
 tb/tb_calc_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Keypad-driven operand entry and ALU request sequencer.
// Builds two hex operands from digit keys and hands them to an external ALU.
module calc_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       key,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             alu_req,
    input  logic             alu_ack,
    input  logic [WIDTH-1:0] alu_res,
    output logic             sel_b,
    output logic [WIDTH-1:0] disp,
    output logic             busy
);

    localparam logic [1:0] S_WREL     = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_WAIT_ACK = 2'd3;

    localparam logic [4:0] KEY_9    = 5'h09;
    localparam logic [4:0] KEY_A    = 5'h0A;
    localparam logic [4:0] KEY_B    = 5'h0B;
    localparam logic [4:0] KEY_F    = 5'h0F;
    localparam logic [4:0] KEY_NONE = 5'h1F;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_alu_req;
    logic             r_sel_b;

    logic             w_is_digit;
    logic             w_is_sel;
    logic             w_is_op;
    logic             w_is_none;
    logic             w_ack;
    logic [2:0]       w_op_code;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;

    assign w_is_digit = (key <= KEY_9);
    assign w_is_sel   = (key == KEY_A);
    assign w_is_op    = (key >= KEY_B) && (key <= KEY_F);
    assign w_is_none  = (key == KEY_NONE);
    // KEY_B..KEY_F have low bits 3..7, so subtracting 3 yields ADD..XOR
    assign w_op_code  = key[2:0] - 3'd3;
    assign w_ack      = alu_ack && r_alu_req;
    assign w_a_shift  = {r_op_a[WIDTH-5:0], key[3:0]};
    assign w_b_shift  = {r_op_b[WIDTH-5:0], key[3:0]};

    // Next-state decode; reserved codes leave IDLE untouched
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WREL: begin
                if (w_is_none)
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_is_digit || w_is_sel)
                    w_state_nxt = S_WREL;
                else if (w_is_op)
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_ack)
                    w_state_nxt = S_WREL;
            end
            default: begin
                w_state_nxt = S_WREL;
            end
        endcase
    end

    // State register; reset parks in WREL so a held key is not taken
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_WREL;
        else
            r_state <= w_state_nxt;
    end

    // Operand, selector and ALU handshake registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sel_b   <= 1'b0;
            r_alu_op  <= 3'd0;
            r_alu_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        if (r_sel_b)
                            r_op_b <= w_b_shift;
                        else
                            r_op_a <= w_a_shift;
                    end
                    if (w_is_sel)
                        r_sel_b <= ~r_sel_b;
                    if (w_is_op)
                        r_alu_op <= w_op_code;
                end
                S_ISSUE: begin
                    r_alu_req <= 1'b1;
                end
                S_WAIT_ACK: begin
                    if (w_ack) begin
                        r_op_a    <= alu_res;
                        r_op_b    <= '0;
                        r_sel_b   <= 1'b0;
                        r_alu_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_op  = r_alu_op;
    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign alu_req = r_alu_req;
    assign sel_b   = r_sel_b;
    assign disp    = r_sel_b ? r_op_b : r_op_a;
    assign busy    = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer.
// Expected ALU requests are queued at op-key time and checked at alu_req.
module tb_calc_sequencer;

    localparam int W = 16;
    localparam logic [4:0] NONE = 5'h1F;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [4:0]   key = NONE;
    logic [2:0]   alu_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         alu_req;
    logic         alu_ack = 1'b0;
    logic [W-1:0] alu_res = '0;
    logic         sel_b;
    logic [W-1:0] disp;
    logic         busy;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_sel;

    calc_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .alu_op  (alu_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .alu_req (alu_req),
        .alu_ack (alu_ack),
        .alu_res (alu_res),
        .sel_b   (sel_b),
        .disp    (disp),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] alu_model(exp_t e);
        case (e.op)
            3'd0: return e.a + e.b;
            3'd1: return e.a - e.b;
            3'd2: return e.a & e.b;
            3'd3: return e.a | e.b;
            default: return e.a ^ e.b;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        key = NONE;
        alu_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        m_a = '0;
        m_b = '0;
        m_sel = 1'b0;
    endtask

    task automatic press(input logic [4:0] k);
        key = k;
        tick();
        key = NONE;
        tick();
        if (k <= 5'h09) begin
            if (m_sel)
                m_b = {m_b[W-5:0], k[3:0]};
            else
                m_a = {m_a[W-5:0], k[3:0]};
        end else if (k == 5'h0A) begin
            m_sel = ~m_sel;
        end
    endtask

    task automatic check_model(input string tag);
        checks++;
        if (op_a !== m_a || op_b !== m_b || sel_b !== m_sel) begin
            errors++;
            $display("FAIL %s a=%h b=%h sel=%b want a=%h b=%h sel=%b",
                     tag, op_a, op_b, sel_b, m_a, m_b, m_sel);
        end
        checks++;
        if (disp !== (m_sel ? m_b : m_a)) begin
            errors++;
            $display("FAIL %s_disp got %h want %h",
                     tag, disp, m_sel ? m_b : m_a);
        end
    endtask

    task automatic do_op(input logic [4:0] k, input int dly,
                         input bit hold);
        exp_t e;
        int lat;
        logic [W-1:0] res;
        e.op = 3'(k - 5'h0B);
        e.a = m_a;
        e.b = m_b;
        q.push_back(e);
        key = k;
        tick();
        key = hold ? k : NONE;
        checks++;
        if (busy !== 1'b1 || alu_req !== 1'b0) begin
            errors++;
            $display("FAIL issue busy=%b req=%b want 1 0", busy, alu_req);
        end
        lat = 1;
        while (!alu_req && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL req_latency got %0d want 2", lat);
        end
        e = q.pop_front();
        if (!alu_req) return;
        checks++;
        if (alu_op !== e.op || op_a !== e.a || op_b !== e.b) begin
            errors++;
            $display("FAIL req op=%0d a=%h b=%h want op=%0d a=%h b=%h",
                     alu_op, op_a, op_b, e.op, e.a, e.b);
        end
        repeat (dly) tick();
        checks++;
        if (alu_req !== 1'b1 || busy !== 1'b1 || op_a !== e.a
            || op_b !== e.b || alu_op !== e.op) begin
            errors++;
            $display("FAIL hold req=%b busy=%b a=%h b=%h want 1 1 %h %h",
                     alu_req, busy, op_a, op_b, e.a, e.b);
        end
        res = alu_model(e);
        alu_res = res;
        alu_ack = 1'b1;
        tick();
        alu_ack = 1'b0;
        alu_res = 16'hDEAD;
        m_a = res;
        m_b = '0;
        m_sel = 1'b0;
        check_model("ack");
        checks++;
        if (alu_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_req req=%b busy=%b want 0 0", alu_req, busy);
        end
        if (hold) begin
            repeat (5) tick();
            checks++;
            if (alu_req !== 1'b0 || busy !== 1'b0 || op_a !== m_a) begin
                errors++;
                $display("FAIL held_key req=%b busy=%b a=%h want 0 0 %h",
                         alu_req, busy, op_a, m_a);
            end
            checks++;
            if (alu_op !== e.op) begin
                errors++;
                $display("FAIL held_op got %0d want %0d", alu_op, e.op);
            end
            key = NONE;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        key = 5'h03;
        tick();
        tick();
        checks++;
        if (op_a !== '0 || op_b !== '0 || sel_b !== 1'b0 || alu_req !== 1'b0
            || busy !== 1'b0 || alu_op !== 3'd0 || disp !== '0) begin
            errors++;
            $display("FAIL reset a=%h b=%h sel=%b req=%b busy=%b op=%0d",
                     op_a, op_b, sel_b, alu_req, busy, alu_op);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (op_a !== '0) begin
            errors++;
            $display("FAIL reset_held_key got %h want 0000", op_a);
        end
        key = NONE;
        tick();
        m_a = '0;
        m_b = '0;
        m_sel = 1'b0;
        press(5'h03);
        check_model("post_reset_key");
    endtask

    task automatic test_digits();
        do_reset();
        press(5'h01);
        press(5'h02);
        checks++;
        if (op_a !== 16'h0012 || sel_b !== 1'b0 || disp !== 16'h0012) begin
            errors++;
            $display("FAIL digits a=%h sel=%b disp=%h want 0012 0 0012",
                     op_a, sel_b, disp);
        end
        press(5'h15);
        alu_res = 16'hFFFF;
        alu_ack = 1'b1;
        tick();
        alu_ack = 1'b0;
        check_model("reserved_and_stray_ack");
    endtask

    task automatic test_add();
        press(5'h0A);
        check_model("toggle");
        press(5'h05);
        check_model("operand_b");
        do_op(5'h0B, 3, 1'b0);
        checks++;
        if (op_a !== 16'h0017) begin
            errors++;
            $display("FAIL add_result got %h want 0017", op_a);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int d = 1; d <= 5; d++)
            press(5'(d));
        checks++;
        if (op_a !== 16'h2345) begin
            errors++;
            $display("FAIL wrap got %h want 2345", op_a);
        end
    endtask

    task automatic test_hold_digit();
        key = 5'h07;
        repeat (10) tick();
        key = NONE;
        tick();
        m_a = {m_a[W-5:0], 4'h7};
        check_model("hold_digit");
    endtask

    task automatic test_hold_op();
        press(5'h0A);
        press(5'h08);
        do_op(5'h0C, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(5'h03);
        press(5'h04);
        press(5'h0A);
        press(5'h01);
        press(5'h02);
        do_op(5'h0C, 1, 1'b0);
        press(5'h0A);
        press(5'h07);
        do_op(5'h0D, 0, 1'b0);
        press(5'h0A);
        press(5'h08);
        do_op(5'h0E, 4, 1'b0);
        press(5'h0A);
        press(5'h09);
        press(5'h09);
        do_op(5'h0F, 2, 1'b0);
        checks++;
        if (op_a !== 16'h0093) begin
            errors++;
            $display("FAIL chain got %h want 0093", op_a);
        end
    endtask

    task automatic test_reset_wait_ack();
        do_reset();
        press(5'h06);
        press(5'h0A);
        press(5'h02);
        key = 5'h0D;
        tick();
        key = NONE;
        tick();
        checks++;
        if (alu_req !== 1'b1) begin
            errors++;
            $display("FAIL rwa_req got %b want 1", alu_req);
        end
        key = 5'h04;
        rst = 1'b0;
        tick();
        checks++;
        if (alu_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rwa_drop req=%b busy=%b want 0 0", alu_req, busy);
        end
        rst = 1'b1;
        alu_res = 16'hBEEF;
        alu_ack = 1'b1;
        tick();
        tick();
        alu_ack = 1'b0;
        checks++;
        if (op_a !== '0 || op_b !== '0 || sel_b !== 1'b0 || alu_req !== 1'b0
            || busy !== 1'b0 || alu_op !== 3'd0 || disp !== '0) begin
            errors++;
            $display("FAIL rwa_state a=%h b=%h sel=%b req=%b busy=%b op=%0d",
                     op_a, op_b, sel_b, alu_req, busy, alu_op);
        end
        key = NONE;
        tick();
        m_a = '0;
        m_b = '0;
        m_sel = 1'b0;
        press(5'h04);
        check_model("rwa_wrel");
    endtask

    initial begin
        m_a = '0;
        m_b = '0;
        m_sel = 1'b0;
        test_reset();
        test_digits();
        test_add();
        test_wrap();
        test_hold_digit();
        test_hold_op();
        test_back_to_back();
        test_reset_wait_ack();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_left got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
